// File: rtl/sequenciador_movimentos_if.sv
// Bundles the move-memory read port, the motor-driver handshake and the
// control/status lines of the move sequencer.
//   slave  : sequencer side (drives endereco, face, inicia_motor, contagem,
//            pronto, erro, db_estado; receives iniciar, movimento, motor_pronto)
//   master : environment side (control unit + move memory + motor driver)
interface sequenciador_movimentos_if #(parameter int ADDR_WIDTH = 5);
  logic                  iniciar;
  logic [2:0]            movimento;
  logic [ADDR_WIDTH-1:0] endereco;
  logic [2:0]            face;
  logic                  inicia_motor;
  logic                  motor_pronto;
  logic [ADDR_WIDTH-1:0] contagem;
  logic                  pronto;
  logic                  erro;
  logic [3:0]            db_estado;

  modport slave (
    input  iniciar, movimento, motor_pronto,
    output endereco, face, inicia_motor, contagem, pronto, erro, db_estado
  );
  modport master (
    output iniciar, movimento, motor_pronto,
    input  endereco, face, inicia_motor, contagem, pronto, erro, db_estado
  );
endinterface

// File: rtl/sequenciador_movimentos.sv
// Move-list sequencer: walks the move memory from address 0, decodes each
// 3-bit code into a face command, fires the motor driver with a one-cycle
// inicia_motor pulse, waits for motor_pronto (with timeout), idles a settle
// period and advances. Ends on code 000 or after the last address (pronto),
// or on code 111 / timeout (erro, held until the next start).
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : iniciar/movimento/motor_pronto in; endereco, face,
//                  inicia_motor, contagem, pronto, erro, db_estado out
module sequenciador_movimentos #(
  parameter int ADDR_WIDTH     = 5,
  parameter int SETTLE_CYCLES  = 50000,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic                     clock,
  input  logic                     reset,
  sequenciador_movimentos_if.slave bus
);
  localparam logic [3:0] OCIOSO     = 4'd0;
  localparam logic [3:0] ZERA       = 4'd1;
  localparam logic [3:0] LE         = 4'd2;
  localparam logic [3:0] DECODIFICA = 4'd3;
  localparam logic [3:0] DISPARA    = 4'd4;
  localparam logic [3:0] AGUARDA    = 4'd5;
  localparam logic [3:0] ESPERA     = 4'd6;
  localparam logic [3:0] PROXIMO    = 4'd7;
  localparam logic [3:0] FIM        = 4'd8;
  localparam logic [3:0] ERRO       = 4'd9;

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  // Counters compare against the value they hold on the final cycle of the
  // window, so the window is exactly N cycles long.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);

  logic [3:0]            state;
  logic [ADDR_WIDTH-1:0] endereco, contagem;
  logic [2:0]            face;
  logic                  erro;
  logic [TW-1:0]         tmo_cnt;
  logic [SW-1:0]         set_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= OCIOSO;
      endereco <= '0;
      contagem <= '0;
      face     <= '0;
      erro     <= 1'b0;
      tmo_cnt  <= '0;
      set_cnt  <= '0;
    end else begin
      case (state)
        OCIOSO: if (bus.iniciar) state <= ZERA;
        ZERA: begin
          endereco <= '0;
          contagem <= '0;
          erro     <= 1'b0;
          tmo_cnt  <= '0;
          set_cnt  <= '0;
          state    <= LE;
        end
        LE: state <= DECODIFICA;     // synchronous RAM: data valid next cycle
        DECODIFICA: begin
          if (bus.movimento == 3'b000) state <= FIM;
          else if (bus.movimento == 3'b111) begin
            erro  <= 1'b1;
            state <= ERRO;
          end else begin
            face  <= bus.movimento;
            state <= DISPARA;
          end
        end
        DISPARA: begin
          tmo_cnt <= '0;
          state   <= AGUARDA;
        end
        AGUARDA: begin
          // completion has priority over a timeout landing on the same cycle
          if (bus.motor_pronto) begin
            set_cnt <= '0;
            state   <= ESPERA;
          end else if (tmo_cnt == TMO_LAST) begin
            erro  <= 1'b1;
            state <= ERRO;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ESPERA: begin
          if (set_cnt == SET_LAST) state <= PROXIMO;
          else set_cnt <= set_cnt + 1'b1;
        end
        PROXIMO: begin
          contagem <= contagem + 1'b1;   // wraps to 0 on a full list
          if (endereco == '1) state <= FIM;
          else begin
            endereco <= endereco + 1'b1;
            state    <= LE;
          end
        end
        FIM:  state <= OCIOSO;
        ERRO: if (bus.iniciar) state <= ZERA;
        default: state <= OCIOSO;
      endcase
    end
  end

  assign bus.endereco     = endereco;
  assign bus.contagem     = contagem;
  assign bus.face         = face;
  assign bus.erro         = erro;
  assign bus.inicia_motor = (state == DISPARA);
  assign bus.pronto       = (state == FIM);
  assign bus.db_estado    = state;
endmodule

// File: tb/tb_sequenciador_movimentos.sv
module tb_sequenciador_movimentos;
  localparam int AW = 3;
  localparam int NA = 1 << AW;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sequenciador_movimentos_if #(.ADDR_WIDTH(AW)) bus ();
  sequenciador_movimentos #(.ADDR_WIDTH(AW), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(16))
    dut (.clock(clock), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  // ---------------- environment: memory + driver model ----------------
  logic [2:0] mem [NA];
  logic ini = 1'b0, spur_mp = 1'b0;
  int   drv_delay = 3, drv_silent_turn = 0;
  int   drv_cnt, drv_turn;
  logic drv_act, drv_mp;

  assign bus.iniciar      = ini;
  assign bus.motor_pronto = drv_mp | spur_mp;
  assign drv_mp = drv_act && (drv_cnt == drv_delay);

  always @(posedge clock) bus.movimento <= mem[bus.endereco];

  // answers motor_pronto drv_delay cycles after each inicia_motor pulse,
  // except for the turn numbered drv_silent_turn
  always @(posedge clock) begin
    if (reset) begin
      drv_act <= 1'b0; drv_cnt <= 0; drv_turn <= 0;
    end else if (bus.inicia_motor) begin
      drv_turn <= drv_turn + 1;
      drv_act  <= (drv_turn + 1 != drv_silent_turn);
      drv_cnt  <= 1;
    end else if (drv_act) begin
      if (drv_mp) drv_act <= 1'b0;
      drv_cnt <= drv_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ini = 1'b0; spur_mp = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  // ---------------- reference model ----------------
  int exp_faces[$];
  bit exp_err;
  int exp_cnt, exp_addr;

  // the list runs from address 0 until a marker, an invalid code, or the end
  task automatic model();
    exp_faces.delete(); exp_err = 0; exp_addr = 0;
    for (int a = 0; a < NA; a++) begin
      exp_addr = a;
      if (mem[a] == 3'd0) break;
      if (mem[a] == 3'd7) begin exp_err = 1; break; end
      exp_faces.push_back(int'(mem[a]));
    end
    exp_cnt = exp_faces.size() % NA;
  endtask

  // ---------------- run monitor ----------------
  int obs_faces[$];
  bit obs_pronto, obs_err, obs_hang;
  int pronto_cyc, first_pulse, gap_bad, obs_wait;

  // pulses iniciar; cycle 0 = first cycle after the edge that samples it
  task automatic run_seq(input int gap_exp, input bit spur);
    int cyc, last;
    bit fin;
    obs_faces.delete(); obs_pronto = 0; obs_err = 0; obs_hang = 0;
    pronto_cyc = -1; first_pulse = -1; gap_bad = 0; obs_wait = 0;
    last = -1; fin = 0; cyc = 0;
    ini = 1'b1;
    step();
    ini = 1'b0;
    while (!fin && cyc < 2000) begin
      if (bus.inicia_motor) begin
        obs_faces.push_back(int'(bus.face));
        if (gap_exp > 0 && last >= 0 && cyc - last != gap_exp) gap_bad++;
        if (first_pulse < 0) first_pulse = cyc;
        last = cyc;
        obs_wait = 0;
      end
      if (bus.db_estado == 4'd5) obs_wait++;
      if (bus.pronto) begin obs_pronto = 1; pronto_cyc = cyc; fin = 1; end
      if (bus.db_estado == 4'd9) begin obs_err = 1; fin = 1; end
      ini     = spur && (bus.db_estado == 4'd6);
      spur_mp = spur && (bus.db_estado == 4'd6);
      step();
      cyc++;
    end
    ini = 1'b0; spur_mp = 1'b0;
    if (!fin) obs_hang = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; ini = 1'b0; spur_mp = 1'b0;
    step(); step();
    total++; if ({bus.endereco, bus.face, bus.inicia_motor, bus.contagem, bus.pronto, bus.erro} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%0h exp=0", {bus.endereco, bus.face, bus.inicia_motor, bus.contagem, bus.pronto, bus.erro}); end
    total++; if (bus.db_estado !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.db_estado); end
    reset = 1'b0;
    step();
    total++; if (bus.db_estado !== 4'd0) begin bad++; $display("FAIL idle_hold got=%0d exp=0", bus.db_estado); end
  endtask

  task automatic test_basic();
    do_reset();
    foreach (mem[i]) mem[i] = 3'd0;
    mem[0] = 3'd1; mem[1] = 3'd4; mem[2] = 3'd6;
    model();
    run_seq(11, 1'b0);
    total++; if (obs_faces !== exp_faces) begin bad++; $display("FAIL basic_faces got=%p exp=%p", obs_faces, exp_faces); end
    total++; if (first_pulse !== 3) begin bad++; $display("FAIL basic_first_pulse got=%0d exp=3", first_pulse); end
    total++; if (gap_bad !== 0) begin bad++; $display("FAIL basic_gap got=%0d exp=0", gap_bad); end
    total++; if (!obs_pronto || obs_hang) begin bad++; $display("FAIL basic_pronto got=%0d exp=1", obs_pronto); end
    total++; if (int'(bus.contagem) !== 3 || bus.erro !== 1'b0) begin
      bad++; $display("FAIL basic_status got=%0d/%0d exp=3/0", bus.contagem, bus.erro); end
    total++; if (bus.db_estado !== 4'd0) begin bad++; $display("FAIL basic_back_idle got=%0d exp=0", bus.db_estado); end
  endtask

  task automatic test_empty();
    do_reset();
    foreach (mem[i]) mem[i] = 3'd0;
    run_seq(0, 1'b0);
    total++; if (obs_faces.size() !== 0) begin bad++; $display("FAIL empty_pulses got=%0d exp=0", obs_faces.size()); end
    total++; if (pronto_cyc !== 3) begin bad++; $display("FAIL empty_latency got=%0d exp=3", pronto_cyc); end
    total++; if (bus.contagem !== '0) begin bad++; $display("FAIL empty_count got=%0d exp=0", bus.contagem); end
  endtask

  task automatic test_invalid();
    do_reset();
    foreach (mem[i]) mem[i] = 3'd0;
    mem[0] = 3'd2; mem[1] = 3'd7;
    run_seq(0, 1'b0);
    total++; if (obs_faces.size() !== 1 || (obs_faces.size() == 1 && obs_faces[0] !== 2)) begin
      bad++; $display("FAIL inv_faces got=%p exp={2}", obs_faces); end
    total++; if (!obs_err || bus.erro !== 1'b1 || int'(bus.contagem) !== 1) begin
      bad++; $display("FAIL inv_status got=err%0d/%0d cnt%0d exp=1/1 1", obs_err, bus.erro, bus.contagem); end
    repeat (5) step();
    total++; if (bus.erro !== 1'b1) begin bad++; $display("FAIL inv_held got=%0d exp=1", bus.erro); end
    mem[0] = 3'd5; mem[1] = 3'd0;
    run_seq(0, 1'b0);
    total++; if (obs_faces.size() !== 1 || (obs_faces.size() == 1 && obs_faces[0] !== 5) || !obs_pronto) begin
      bad++; $display("FAIL inv_restart got=%p pronto%0d exp={5} 1", obs_faces, obs_pronto); end
    total++; if (bus.erro !== 1'b0) begin bad++; $display("FAIL inv_cleared got=%0d exp=0", bus.erro); end
  endtask

  task automatic test_timeout();
    do_reset();
    foreach (mem[i]) mem[i] = 3'd0;
    mem[0] = 3'd1; mem[1] = 3'd2;
    drv_silent_turn = 2;
    run_seq(0, 1'b0);
    drv_silent_turn = 0;
    total++; if (!obs_err || obs_faces.size() !== 2) begin bad++; $display("FAIL tmo_err got=%0d/%0d exp=1/2", obs_err, obs_faces.size()); end
    total++; if (obs_wait !== 16) begin bad++; $display("FAIL tmo_wait got=%0d exp=16", obs_wait); end
    total++; if (bus.erro !== 1'b1 || int'(bus.contagem) !== 1) begin
      bad++; $display("FAIL tmo_status got=%0d/%0d exp=1/1", bus.erro, bus.contagem); end
    // boundary: completion on the 16th waiting cycle is accepted
    do_reset();
    mem[0] = 3'd3; mem[1] = 3'd0;
    drv_delay = 16;
    run_seq(0, 1'b0);
    drv_delay = 3;
    total++; if (!obs_pronto || obs_err || bus.erro !== 1'b0 || int'(bus.contagem) !== 1) begin
      bad++; $display("FAIL tmo_boundary got=pronto%0d err%0d cnt%0d exp=1 0 1", obs_pronto, obs_err, bus.contagem); end
  endtask

  task automatic test_full();
    do_reset();
    foreach (mem[i]) mem[i] = 3'($urandom_range(1, 6));
    model();
    run_seq(11, 1'b0);
    total++; if (obs_faces !== exp_faces || obs_faces.size() !== 8) begin
      bad++; $display("FAIL full_faces got=%p exp=%p", obs_faces, exp_faces); end
    total++; if (!obs_pronto || bus.contagem !== '0 || int'(bus.endereco) !== 7 || gap_bad !== 0) begin
      bad++; $display("FAIL full_end got=pronto%0d cnt%0d addr%0d gap%0d exp=1 0 7 0", obs_pronto, bus.contagem, bus.endereco, gap_bad); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 15; it++) begin
      do_reset();
      foreach (mem[i]) begin
        int r;
        r = $urandom_range(0, 11);
        mem[i] = (r == 0) ? 3'd0 : (r == 1) ? 3'd7 : 3'($urandom_range(1, 6));
      end
      model();
      run_seq(11, 1'b0);
      total++; if (obs_faces !== exp_faces || obs_err !== exp_err || obs_pronto === exp_err || gap_bad !== 0) begin
        bad++; $display("FAIL rand%0d_seq got=%p err%0d exp=%p err%0d", it, obs_faces, obs_err, exp_faces, exp_err); end
      total++; if (int'(bus.contagem) !== exp_cnt || int'(bus.endereco) !== exp_addr || bus.erro !== exp_err) begin
        bad++; $display("FAIL rand%0d_status got=cnt%0d addr%0d err%0d exp=cnt%0d addr%0d err%0d",
                        it, bus.contagem, bus.endereco, bus.erro, exp_cnt, exp_addr, exp_err); end
    end
  endtask

  task automatic test_spurious();
    do_reset();
    foreach (mem[i]) mem[i] = 3'd0;
    mem[0] = 3'd6; mem[1] = 3'd3; mem[2] = 3'd2;
    model();
    run_seq(11, 1'b1);
    total++; if (obs_faces !== exp_faces || gap_bad !== 0 || !obs_pronto) begin
      bad++; $display("FAIL spur_seq got=%p gap%0d exp=%p gap0", obs_faces, gap_bad, exp_faces); end
  endtask

  task automatic test_reset_mid();
    int pulses, cyc;
    do_reset();
    foreach (mem[i]) mem[i] = 3'd0;
    mem[0] = 3'd1; mem[1] = 3'd2; mem[2] = 3'd3;
    pulses = 0; cyc = 0;
    ini = 1'b1; step(); ini = 1'b0;
    while (!(pulses == 2 && bus.db_estado == 4'd5) && cyc < 200) begin
      if (bus.inicia_motor) pulses++;
      step(); cyc++;
    end
    total++; if (cyc >= 200) begin bad++; $display("FAIL mid_reach got=%0d exp<200", cyc); end
    step();
    reset = 1'b1;
    step();
    total++; if ({bus.endereco, bus.face, bus.inicia_motor, bus.contagem, bus.pronto, bus.erro, bus.db_estado} !== '0) begin
      bad++; $display("FAIL mid_reset got=%0h exp=0", {bus.endereco, bus.face, bus.inicia_motor, bus.contagem, bus.pronto, bus.erro, bus.db_estado}); end
    reset = 1'b0;
    pulses = 0;
    repeat (30) begin
      if (bus.inicia_motor || bus.db_estado != 4'd0) pulses++;
      step();
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL mid_quiet got=%0d exp=0", pulses); end
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 3'd0;
    test_reset();
    test_basic();
    test_empty();
    test_invalid();
    test_timeout();
    test_full();
    test_random();
    test_spurious();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
